// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-indexed data memory: lane select, extension, sub-word RMW.
// Latency from accept edge: error 1 cycle, load/word store 2 cycles, sub-word store 3 cycles.
// Single request in flight; Req_Ready is low from accept until the cycle after the response.
module mem_access_unit #(
    parameter int DEPTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Req_Valid,
    output logic             Req_Ready,
    input  logic             Req_Write,
    input  logic [1:0]       Req_Size,
    input  logic             Req_Signed,
    input  logic [31:0]      Req_Addr,
    input  logic [31:0]      Req_WData,
    output logic             Rsp_Valid,
    output logic [31:0]      Rsp_RData,
    output logic             Rsp_Error,
    output logic [IDX_W-1:0] Adress,
    output logic [31:0]      Write_Data,
    output logic             MemWrite,
    output logic             MemRead,
    input  logic [31:0]      Read_Data
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    state_t      state;
    logic        write_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [1:0]  lane_q;
    logic [15:0] wdata_q;

    logic        req_err;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ld_data;
    logic [31:0] st_word;

    // Decode alignment, size legality and range of the incoming request
    always_comb begin
        req_err = 1'b0;
        if (Req_Size == 2'b11)                              req_err = 1'b1;
        if (Req_Size == 2'b01 && Req_Addr[0])               req_err = 1'b1;
        if (Req_Size == 2'b10 && Req_Addr[1:0] != 2'b00)    req_err = 1'b1;
        if (Req_Addr >= 32'(4 * DEPTH))                     req_err = 1'b1;
    end

    // Extract the addressed lane for loads and build the merged word for sub-word stores
    always_comb begin
        rd_byte = Read_Data[{lane_q, 3'b000} +: 8];
        rd_half = Read_Data[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            2'b00:   ld_data = signed_q ? {{24{rd_byte[7]}}, rd_byte} : {24'b0, rd_byte};
            2'b01:   ld_data = signed_q ? {{16{rd_half[15]}}, rd_half} : {16'b0, rd_half};
            default: ld_data = Read_Data;
        endcase
        st_word = Read_Data;
        if (size_q == 2'b00)
            st_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            st_word[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end

    // Access sequencer with all handshake and memory-side outputs registered
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state      <= IDLE;
            write_q    <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= 2'b00;
            lane_q     <= 2'b00;
            wdata_q    <= 16'b0;
            Req_Ready  <= 1'b1;
            Rsp_Valid  <= 1'b0;
            Rsp_RData  <= 32'b0;
            Rsp_Error  <= 1'b0;
            Adress     <= '0;
            Write_Data <= 32'b0;
            MemWrite   <= 1'b0;
            MemRead    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Req_Valid) begin
                        write_q   <= Req_Write;
                        signed_q  <= Req_Signed;
                        size_q    <= Req_Size;
                        lane_q    <= Req_Addr[1:0];
                        wdata_q   <= Req_WData[15:0];
                        Req_Ready <= 1'b0;
                        if (req_err) begin
                            Rsp_Valid <= 1'b1;
                            Rsp_Error <= 1'b1;
                            state     <= RESP;
                        end else if (Req_Write && Req_Size == 2'b10) begin
                            // Full-word store skips the read
                            Adress     <= Req_Addr[IDX_W+1:2];
                            Write_Data <= Req_WData;
                            MemWrite   <= 1'b1;
                            state      <= WR;
                        end else begin
                            Adress  <= Req_Addr[IDX_W+1:2];
                            MemRead <= 1'b1;
                            state   <= RD;
                        end
                    end
                end
                RD: begin
                    MemRead <= 1'b0;
                    if (write_q) begin
                        // Adress stays put so the write hits the word just read
                        Write_Data <= st_word;
                        MemWrite   <= 1'b1;
                        state      <= WR;
                    end else begin
                        Adress    <= '0;
                        Rsp_RData <= ld_data;
                        Rsp_Valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                WR: begin
                    MemWrite   <= 1'b0;
                    Adress     <= '0;
                    Write_Data <= 32'b0;
                    Rsp_Valid  <= 1'b1;
                    state      <= RESP;
                end
                default: begin
                    Rsp_Valid <= 1'b0;
                    Rsp_RData <= 32'b0;
                    Rsp_Error <= 1'b0;
                    Req_Ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed and random load/store traffic against a byte-level model.
// Memory is a bench-owned 32x32 array with combinational read and write on MemWrite.
// One request at a time; every response is checked for data, error, latency and bus activity.
module tb_mem_access_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        Req_Valid;
    logic        Req_Ready;
    logic        Req_Write;
    logic [1:0]  Req_Size;
    logic        Req_Signed;
    logic [31:0] Req_Addr;
    logic [31:0] Req_WData;
    logic        Rsp_Valid;
    logic [31:0] Rsp_RData;
    logic        Rsp_Error;
    logic [4:0]  Adress;
    logic [31:0] Write_Data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Read_Data;

    logic [31:0] mem [0:31];
    logic [7:0]  ref_b [0:127];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    mem_access_unit #(.DEPTH(32), .IDX_W(5)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req_Valid(Req_Valid), .Req_Ready(Req_Ready), .Req_Write(Req_Write),
        .Req_Size(Req_Size), .Req_Signed(Req_Signed), .Req_Addr(Req_Addr),
        .Req_WData(Req_WData), .Rsp_Valid(Rsp_Valid), .Rsp_RData(Rsp_RData),
        .Rsp_Error(Rsp_Error), .Adress(Adress), .Write_Data(Write_Data),
        .MemWrite(MemWrite), .MemRead(MemRead), .Read_Data(Read_Data)
    );

    assign Read_Data = mem[Adress];

    always @(posedge Clk) if (MemWrite) mem[Adress] <= Write_Data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int idx, input logic [31:0] w);
        mem[idx] = w;
        for (int i = 0; i < 4; i++) ref_b[4*idx+i] = w[8*i +: 8];
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_b[4*idx+3], ref_b[4*idx+2], ref_b[4*idx+1], ref_b[4*idx]};
    endfunction

    function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'd3) return 1'b1;
        if (addr >= 32'd128) return 1'b1;
        if (addr % (32'd1 << size) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Little-endian load of 1/2/4 bytes, two's-complement extension by arithmetic
    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
        int    n = 1 << size;
        longint v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_b[int'(addr) + i]) << (8 * i);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] d);
        int n = 1 << size;
        for (int i = 0; i < n; i++) ref_b[int'(addr) + i] = d[8*i +: 8];
    endtask

    // Issue one request, watch the bus until the response, and compare with the model
    task automatic do_req(input string tag, input logic wr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wd);
        bit          err    = ref_err(size, addr);
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_data;
        int          lat    = 0;
        int          n_rd   = 0;
        int          n_wr   = 0;
        bit          overlap = 1'b0;
        bit          bad_idx = 1'b0;
        bit          busy_rdy = 1'b0;
        logic [31:0] wdat   = 32'b0;
        int          idx    = int'(addr[6:2]);

        if (err) begin
            exp_lat = 1; exp_rd = 0; exp_wr = 0; exp_data = 0;
        end else if (!wr) begin
            exp_lat = 2; exp_rd = 1; exp_wr = 0; exp_data = ref_load(size, sgn, addr);
        end else begin
            exp_lat = (size == 2'd2) ? 2 : 3;
            exp_rd  = (size == 2'd2) ? 0 : 1;
            exp_wr  = 1; exp_data = 0;
            ref_store(size, addr, wd);
        end

        Req_Valid = 1'b1; Req_Write = wr; Req_Size = size; Req_Signed = sgn;
        Req_Addr = addr; Req_WData = wd;
        @(posedge Clk); #1;
        Req_Valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (MemRead && MemWrite) overlap = 1'b1;
            if (MemRead) begin n_rd++; if (int'(Adress) != idx) bad_idx = 1'b1; end
            if (MemWrite) begin n_wr++; wdat = Write_Data; if (int'(Adress) != idx) bad_idx = 1'b1; end
            if (Rsp_Valid) begin lat = c; break; end
            if (Req_Ready) busy_rdy = 1'b1;
            @(posedge Clk); #1;
        end
        chk({tag, " latency"}, lat, exp_lat);
        if (lat != 0) begin
            chk({tag, " rdata"}, Rsp_RData, exp_data);
            chk({tag, " error"}, {31'b0, Rsp_Error}, {31'b0, err});
            chk({tag, " ready_in_resp"}, {31'b0, Req_Ready}, 32'd0);
        end
        chk({tag, " memread_cycles"}, n_rd, exp_rd);
        chk({tag, " memwrite_cycles"}, n_wr, exp_wr);
        chk({tag, " rd_wr_overlap"}, {31'b0, overlap}, 32'd0);
        chk({tag, " adress"}, {31'b0, bad_idx}, 32'd0);
        chk({tag, " ready_while_busy"}, {31'b0, busy_rdy}, 32'd0);
        if (exp_wr == 1) chk({tag, " write_data"}, wdat, ref_word(idx));
        @(posedge Clk); #1;
        chk({tag, " post_valid"}, {31'b0, Rsp_Valid}, 32'd0);
        chk({tag, " post_rdata"}, Rsp_RData, 32'd0);
        chk({tag, " post_ready"}, {31'b0, Req_Ready}, 32'd1);
        if (!err) chk({tag, " mem_word"}, mem[idx], ref_word(idx));
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  s;
        int          r;
        bit          saw_mem;

        for (int i = 0; i < 32; i++) set_word(i, $urandom);
        set_word(3, 32'h80FF_1234);
        Reset_n = 1'b0; Req_Valid = 1'b1; Req_Write = 1'b1; Req_Size = 2'b10;
        Req_Signed = 1'b0; Req_Addr = 32'h0C; Req_WData = 32'h1111_2222;

        // Reset held with a pending request: outputs idle, no memory strobes
        saw_mem = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge Clk); #1;
            if (MemRead || MemWrite) saw_mem = 1'b1;
        end
        chk("rst mem_strobes", {31'b0, saw_mem}, 32'd0);
        chk("rst ready", {31'b0, Req_Ready}, 32'd1);
        chk("rst valid", {31'b0, Rsp_Valid}, 32'd0);
        chk("rst rdata", Rsp_RData, 32'd0);
        chk("rst error", {31'b0, Rsp_Error}, 32'd0);
        chk("rst adress", {27'b0, Adress}, 32'd0);
        chk("rst write_data", Write_Data, 32'd0);
        Req_Valid = 1'b0;
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Directed loads and stores on word 3 and the top word
        do_req("ldb_s_0d", 1'b0, 2'd0, 1'b1, 32'h0D, 32'h0);
        chk("ldb_s_0d value", Rsp_RData, 32'h0);
        do_req("ldh_s_0e", 1'b0, 2'd1, 1'b1, 32'h0E, 32'h0);
        do_req("ldw_0c", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
        do_req("stb_0f", 1'b1, 2'd0, 1'b0, 32'h0F, 32'h0000_00AB);
        chk("stb_0f model", ref_word(3), 32'hABFF_1234);
        do_req("ldw_after_stb", 1'b0, 2'd2, 1'b0, 32'h0C, 32'h0);
        do_req("stw_7c", 1'b1, 2'd2, 1'b0, 32'h7C, 32'hDEAD_BEEF);
        chk("stw_7c mem", mem[31], 32'hDEAD_BEEF);
        do_req("err_ldw_02", 1'b0, 2'd2, 1'b0, 32'h02, 32'h0);
        do_req("err_ldh_03", 1'b0, 2'd1, 1'b0, 32'h03, 32'h0);
        do_req("err_size3", 1'b0, 2'd3, 1'b0, 32'h04, 32'h0);
        do_req("err_oor_80", 1'b0, 2'd2, 1'b0, 32'h80, 32'h0);
        do_req("sth_7e", 1'b1, 2'd1, 1'b0, 32'h7E, 32'h0000_5A5A);
        do_req("ldb_u_7f", 1'b0, 2'd0, 1'b0, 32'h7F, 32'h0);

        // Reset during the read half of a sub-word store
        a = mem[5];
        Req_Valid = 1'b1; Req_Write = 1'b1; Req_Size = 2'd0; Req_Signed = 1'b0;
        Req_Addr = 32'h15; Req_WData = 32'h77;
        @(posedge Clk); #1;
        Req_Valid = 1'b0;
        chk("abort in_rd", {31'b0, MemRead}, 32'd1);
        Reset_n = 1'b0;
        saw_mem = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge Clk); #1;
            if (MemWrite || Rsp_Valid) saw_mem = 1'b1;
        end
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        if (MemWrite || Rsp_Valid) saw_mem = 1'b1;
        chk("abort no_write_no_rsp", {31'b0, saw_mem}, 32'd0);
        chk("abort mem_unchanged", mem[5], a);
        chk("abort ready", {31'b0, Req_Ready}, 32'd1);

        // Random traffic
        for (int t = 0; t < 200; t++) begin
            r = $urandom_range(0, 11);
            a = (r == 0) ? $urandom : 32'($urandom_range(0, 133));
            s = 2'($urandom_range(0, 3));
            if (r > 3 && s == 2'd1) a[0] = 1'b0;
            if (r > 3 && s == 2'd2) a[1:0] = 2'b00;
            do_req("rand", 1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, required finish before limit");
        $fatal(1, "timeout");
    end

endmodule
